// File: rtl/csr_exec_if.sv
// Handshake and CSR-file signals for the SYSTEM-op execute unit.
// slave = the execute unit, master = its environment (decode, CSR file, writeback).
interface csr_exec_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CSR_AW = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [2:0]        in_funct3;
    logic [CSR_AW-1:0] in_csr_addr;
    logic [4:0]        in_rs1_idx;
    logic [XLEN-1:0]   in_rs1_val;
    logic [4:0]        in_rd;
    logic              in_is_ecall;
    logic              in_is_mret;

    logic [CSR_AW-1:0] csr_addr;
    logic [XLEN-1:0]   csr_wdata;
    logic              csr_we;
    logic              csr_ecall;
    logic [XLEN-1:0]   csr_pc;
    logic [XLEN-1:0]   csr_rdata;
    logic [XLEN-1:0]   csr_mtvec;
    logic [XLEN-1:0]   csr_mepc;

    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_rd;
    logic              out_rd_we;
    logic [XLEN-1:0]   out_rd_data;
    logic              out_redirect;
    logic [XLEN-1:0]   out_redirect_pc;

    modport slave (
        input  in_valid, in_pc, in_funct3, in_csr_addr, in_rs1_idx, in_rs1_val, in_rd,
               in_is_ecall, in_is_mret, csr_rdata, csr_mtvec, csr_mepc, out_ready,
        output in_ready, csr_addr, csr_wdata, csr_we, csr_ecall, csr_pc,
               out_valid, out_rd, out_rd_we, out_rd_data, out_redirect, out_redirect_pc
    );

    modport master (
        output in_valid, in_pc, in_funct3, in_csr_addr, in_rs1_idx, in_rs1_val, in_rd,
               in_is_ecall, in_is_mret, csr_rdata, csr_mtvec, csr_mepc, out_ready,
        input  in_ready, csr_addr, csr_wdata, csr_we, csr_ecall, csr_pc,
               out_valid, out_rd, out_rd_we, out_rd_data, out_redirect, out_redirect_pc
    );
endinterface

// File: rtl/csr_exec_unit.sv
// Multicycle execute stage for SYSTEM ops: CSR read-modify-write, ECALL trap entry, MRET return.
// One op in flight; result held in RESP until writeback takes it.
module csr_exec_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CSR_AW = 12
) (
    input logic       clk,
    input logic       rst,
    csr_exec_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StRead, StWrite, StTrap, StRet, StResp} state_e;

    state_e r_state, w_state_next;

    logic [XLEN-1:0]   r_pc;
    logic [2:0]        r_funct3;
    logic [CSR_AW-1:0] r_addr;
    logic [4:0]        r_rs1_idx;
    logic [XLEN-1:0]   r_rs1_val;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_old;
    logic [XLEN-1:0]   r_new;
    logic [XLEN-1:0]   r_target;
    logic              r_rd_we;
    logic              r_redirect;

    logic              w_legal;
    logic              w_does_write;
    logic [XLEN-1:0]   w_src;
    logic [XLEN-1:0]   w_new;

    // funct3 000 and 100 are the non-CSR encodings
    assign w_legal      = (bus.in_funct3[1:0] != 2'b00);
    assign w_does_write = (r_funct3[1:0] == 2'b01) || (r_rs1_idx != 5'd0);
    assign w_src        = r_funct3[2] ? {{(XLEN-5){1'b0}}, r_rs1_idx} : r_rs1_val;

    always_comb begin
        w_new = w_src;
        case (r_funct3[1:0])
            2'b10:   w_new = bus.csr_rdata | w_src;
            2'b11:   w_new = bus.csr_rdata & ~w_src;
            default: w_new = w_src;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    if (bus.in_is_ecall)     w_state_next = StTrap;
                    else if (bus.in_is_mret) w_state_next = StRet;
                    else if (w_legal)        w_state_next = StRead;
                    else                     w_state_next = StResp;
                end
            end
            StRead:  w_state_next = w_does_write ? StWrite : StResp;
            StWrite: w_state_next = StResp;
            StTrap:  w_state_next = StResp;
            StRet:   w_state_next = StResp;
            StResp:  if (bus.out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= '0;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_rs1_idx  <= '0;
            r_rs1_val  <= '0;
            r_rd       <= '0;
            r_old      <= '0;
            r_new      <= '0;
            r_target   <= '0;
            r_rd_we    <= 1'b0;
            r_redirect <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.in_valid) begin
                        r_pc       <= bus.in_pc;
                        r_funct3   <= bus.in_funct3;
                        r_addr     <= bus.in_csr_addr;
                        r_rs1_idx  <= bus.in_rs1_idx;
                        r_rs1_val  <= bus.in_rs1_val;
                        r_rd       <= bus.in_rd;
                        r_old      <= '0;
                        r_new      <= '0;
                        r_target   <= '0;
                        r_rd_we    <= 1'b0;
                        r_redirect <= 1'b0;
                    end
                end
                StRead: begin
                    r_old   <= bus.csr_rdata;
                    r_new   <= w_new;
                    r_rd_we <= (r_rd != 5'd0);
                end
                StTrap: begin
                    r_target   <= bus.csr_mtvec;
                    r_redirect <= 1'b1;
                end
                StRet: begin
                    r_target   <= bus.csr_mepc;
                    r_redirect <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Strobes are gated by rst so a reset landing on WRITE/TRAP commits nothing
    assign bus.csr_we          = (r_state == StWrite) && !rst;
    assign bus.csr_ecall       = (r_state == StTrap) && !rst;
    assign bus.csr_wdata       = bus.csr_we ? r_new : '0;
    assign bus.csr_pc          = bus.csr_ecall ? r_pc : '0;
    assign bus.csr_addr        = r_addr;
    assign bus.in_ready        = (r_state == StIdle);
    assign bus.out_valid       = (r_state == StResp);
    assign bus.out_rd          = r_rd;
    assign bus.out_rd_we       = r_rd_we;
    assign bus.out_rd_data     = r_old;
    assign bus.out_redirect    = r_redirect;
    assign bus.out_redirect_pc = r_target;
endmodule

// File: tb/tb_csr_exec_unit.sv
// Self-checking bench for csr_exec_unit: directed vector table, reset/stall sequences,
// and random ops checked against a CSR-file reference model.
module tb_csr_exec_unit;
    localparam int XLEN = 32;
    localparam int AW   = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csr_exec_if #(.XLEN(XLEN), .CSR_AW(AW)) bus ();

    csr_exec_unit #(.XLEN(XLEN), .CSR_AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // CSR file model: combinational read, write on csr_we
    logic [31:0] csr_mem [0:4095];
    logic        poke_en;
    logic [11:0] poke_addr;
    logic [31:0] poke_data;

    always @(posedge clk) begin
        if (poke_en)          csr_mem[poke_addr]    <= poke_data;
        else if (bus.csr_we)  csr_mem[bus.csr_addr] <= bus.csr_wdata;
    end

    assign bus.csr_rdata = csr_mem[bus.csr_addr];
    assign bus.csr_mtvec = csr_mem[12'h305];
    assign bus.csr_mepc  = csr_mem[12'h341];

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  rs1;
        logic [31:0] rs1v;
        logic [4:0]  rd;
        logic        ecall;
        logic        mret;
    } op_t;

    typedef struct {
        int          lat;
        int          nwe;
        logic [31:0] wdata;
        int          necall;
        logic [31:0] cpc;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] rd_data;
        logic        chk_data;
        logic        redirect;
        logic [31:0] rpc;
    } res_t;

    typedef struct {
        op_t  op;
        int   hold;
        res_t e;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk);
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    function automatic op_t mkop(input logic [31:0] pc, input logic [2:0] f3,
                                 input logic [11:0] addr, input logic [4:0] rs1,
                                 input logic [31:0] rs1v, input logic [4:0] rd,
                                 input logic ec, input logic mr);
        op_t o;
        o.pc = pc; o.f3 = f3; o.addr = addr; o.rs1 = rs1; o.rs1v = rs1v; o.rd = rd;
        o.ecall = ec; o.mret = mr;
        return o;
    endfunction

    function automatic res_t mkres(input int lat, input int nwe, input logic [31:0] wdata,
                                   input int necall, input logic [31:0] cpc, input logic [4:0] rd,
                                   input logic rd_we, input logic [31:0] rd_data,
                                   input logic chk_data, input logic redirect,
                                   input logic [31:0] rpc);
        res_t r;
        r.lat = lat; r.nwe = nwe; r.wdata = wdata; r.necall = necall; r.cpc = cpc; r.rd = rd;
        r.rd_we = rd_we; r.rd_data = rd_data; r.chk_data = chk_data; r.redirect = redirect;
        r.rpc = rpc;
        return r;
    endfunction

    // Reference model: expected result of one op given the current CSR contents
    function automatic res_t model(input op_t op);
        res_t        e;
        logic [31:0] old, src, nv;
        int          kind;
        bit          writes;
        e = mkres(1, 0, 0, 0, 0, op.rd, 0, 0, 0, 0, 0);
        if (op.ecall) begin
            e.lat = 2; e.necall = 1; e.cpc = op.pc; e.redirect = 1; e.rpc = csr_mem[12'h305];
        end else if (op.mret) begin
            e.lat = 2; e.redirect = 1; e.rpc = csr_mem[12'h341];
        end else if (op.f3 inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7}) begin
            old  = csr_mem[op.addr];
            src  = (op.f3 >= 3'd4) ? 32'(op.rs1) : op.rs1v;
            kind = int'(op.f3) % 4;
            if (kind == 1)      nv = src;
            else if (kind == 2) nv = old | src;
            else                nv = old & ~src;
            writes     = (kind == 1) || (op.rs1 != 0);
            e.lat      = writes ? 3 : 2;
            e.nwe      = writes ? 1 : 0;
            e.wdata    = nv;
            e.rd_we    = (op.rd != 0);
            e.rd_data  = old;
            e.chk_data = 1;
        end
        return e;
    endfunction

    task automatic do_op(input string tag, input op_t op, input int hold, output res_t g);
        int  rdy_bad, both, addr_bad, unstable, stray;
        bit  timeout;
        logic [31:0] s_data, s_rpc;
        logic [4:0]  s_rd;
        logic        s_we, s_redir;
        g = mkres(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rdy_bad = 0; both = 0; addr_bad = 0; unstable = 0; stray = 0; timeout = 1;
        @(negedge clk);
        bus.in_pc = op.pc; bus.in_funct3 = op.f3; bus.in_csr_addr = op.addr;
        bus.in_rs1_idx = op.rs1; bus.in_rs1_val = op.rs1v; bus.in_rd = op.rd;
        bus.in_is_ecall = op.ecall; bus.in_is_mret = op.mret;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Scramble inputs so the result must come from captured fields
                bus.in_valid = 1'b0;
                bus.in_pc = $urandom; bus.in_funct3 = 3'($urandom);
                bus.in_csr_addr = 12'($urandom); bus.in_rs1_idx = 5'($urandom);
                bus.in_rs1_val = $urandom; bus.in_rd = 5'($urandom);
                bus.in_is_ecall = 1'($urandom); bus.in_is_mret = 1'($urandom);
            end
            if (bus.csr_we) begin
                g.nwe++; g.wdata = bus.csr_wdata;
                if (bus.csr_addr !== op.addr) addr_bad++;
            end
            if (bus.csr_ecall) begin g.necall++; g.cpc = bus.csr_pc; end
            if (bus.csr_we && bus.csr_ecall) both++;
            if (bus.in_ready) rdy_bad++;
            if (bus.out_valid) begin g.lat = k; timeout = 0; break; end
        end
        chk({tag, " timeout"}, 64'(timeout), 64'd0);
        g.rd = bus.out_rd; g.rd_we = bus.out_rd_we; g.rd_data = bus.out_rd_data;
        g.redirect = bus.out_redirect; g.rpc = bus.out_redirect_pc;
        s_rd = g.rd; s_we = g.rd_we; s_data = g.rd_data; s_redir = g.redirect; s_rpc = g.rpc;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (bus.out_rd !== s_rd || bus.out_rd_we !== s_we || bus.out_rd_data !== s_data ||
                bus.out_redirect !== s_redir || bus.out_redirect_pc !== s_rpc ||
                bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) unstable++;
            if (bus.csr_we || bus.csr_ecall) stray++;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, " in_ready low while busy"}, 64'(rdy_bad), 64'd0);
        chk({tag, " we&ecall overlap"}, 64'(both), 64'd0);
        chk({tag, " write addr"}, 64'(addr_bad), 64'd0);
        chk({tag, " stall stability"}, 64'(unstable + stray), 64'd0);
        chk({tag, " released to idle"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    endtask

    task automatic compare(input string tag, input res_t e, input res_t g);
        chk({tag, " latency"}, 64'(g.lat), 64'(e.lat));
        chk({tag, " csr_we pulses"}, 64'(g.nwe), 64'(e.nwe));
        if (e.nwe != 0) chk({tag, " csr_wdata"}, 64'(g.wdata), 64'(e.wdata));
        chk({tag, " csr_ecall pulses"}, 64'(g.necall), 64'(e.necall));
        if (e.necall != 0) chk({tag, " csr_pc"}, 64'(g.cpc), 64'(e.cpc));
        chk({tag, " out_rd"}, 64'(g.rd), 64'(e.rd));
        chk({tag, " out_rd_we"}, 64'(g.rd_we), 64'(e.rd_we));
        if (e.chk_data) chk({tag, " out_rd_data"}, 64'(g.rd_data), 64'(e.rd_data));
        chk({tag, " out_redirect"}, 64'(g.redirect), 64'(e.redirect));
        if (e.redirect) chk({tag, " out_redirect_pc"}, 64'(g.rpc), 64'(e.rpc));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [10];
        res_t        g, e;
        op_t         op;
        logic [11:0] addrs [5];
        int          cnt;

        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_funct3 = '0; bus.in_csr_addr = '0;
        bus.in_rs1_idx = '0; bus.in_rs1_val = '0; bus.in_rd = '0;
        bus.in_is_ecall = 1'b0; bus.in_is_mret = 1'b0; bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset strobes", {62'd0, bus.csr_we, bus.csr_ecall}, 64'd0);
        chk("reset csr_addr", 64'(bus.csr_addr), 64'd0);
        chk("reset out regs", {bus.out_rd_data, bus.out_redirect_pc}, 64'd0);
        chk("reset out flags", {57'd0, bus.out_rd, bus.out_rd_we, bus.out_redirect}, 64'd0);

        poke(12'h300, 32'h0000_1888);
        poke(12'h305, 32'h8000_0000);
        poke(12'h340, 32'h0000_000F);
        poke(12'h341, 32'h8000_0044);
        poke(12'h342, 32'd11);
        @(negedge clk);
        rst = 1'b0;

        vecs[0] = '{mkop(32'h100, 3'b001, 12'h305, 5'd1, 32'h8000_0100, 5'd5, 0, 0), 0,
                    mkres(3, 1, 32'h8000_0100, 0, 0, 5'd5, 1, 32'h8000_0000, 1, 0, 0)};
        vecs[1] = '{mkop(32'h104, 3'b010, 12'h342, 5'd0, 32'hFFFF_FFFF, 5'd7, 0, 0), 5,
                    mkres(2, 0, 0, 0, 0, 5'd7, 1, 32'd11, 1, 0, 0)};
        vecs[2] = '{mkop(32'h108, 3'b111, 12'h340, 5'd3, 32'hFFFF_FFFF, 5'd0, 0, 0), 0,
                    mkres(3, 1, 32'h0000_000C, 0, 0, 5'd0, 0, 32'h0000_000F, 1, 0, 0)};
        vecs[3] = '{mkop(32'h8000_0040, 3'b000, 12'h000, 5'd0, 32'h0, 5'd0, 1, 0), 2,
                    mkres(2, 0, 0, 1, 32'h8000_0040, 5'd0, 0, 0, 0, 1, 32'h8000_0100)};
        vecs[4] = '{mkop(32'h200, 3'b000, 12'h302, 5'd0, 32'h0, 5'd0, 0, 1), 0,
                    mkres(2, 0, 0, 0, 0, 5'd0, 0, 0, 0, 1, 32'h8000_0044)};
        vecs[5] = '{mkop(32'h204, 3'b000, 12'h340, 5'd4, 32'h5, 5'd9, 0, 0), 1,
                    mkres(1, 0, 0, 0, 0, 5'd9, 0, 0, 0, 0, 0)};
        vecs[6] = '{mkop(32'h208, 3'b100, 12'h340, 5'd4, 32'h5, 5'd3, 0, 0), 0,
                    mkres(1, 0, 0, 0, 0, 5'd3, 0, 0, 0, 0, 0)};
        vecs[7] = '{mkop(32'h20C, 3'b101, 12'h340, 5'd0, 32'hFFFF_FFFF, 5'd2, 0, 0), 0,
                    mkres(3, 1, 32'h0, 0, 0, 5'd2, 1, 32'h0000_000C, 1, 0, 0)};
        vecs[8] = '{mkop(32'h210, 3'b110, 12'h340, 5'h10, 32'h0, 5'd1, 0, 0), 0,
                    mkres(3, 1, 32'h10, 0, 0, 5'd1, 1, 32'h0, 1, 0, 0)};
        vecs[9] = '{mkop(32'h300, 3'b000, 12'h000, 5'd0, 32'h0, 5'd6, 1, 1), 0,
                    mkres(2, 0, 0, 1, 32'h300, 5'd6, 0, 0, 0, 1, 32'h8000_0100)};

        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].hold, g);
            compare($sformatf("vec%0d", i), vecs[i].e, g);
        end

        // Reset landing on the WRITE cycle must discard the op
        poke(12'h340, 32'h0000_1234);
        @(negedge clk);
        bus.in_pc = 32'h400; bus.in_funct3 = 3'b001; bus.in_csr_addr = 12'h340;
        bus.in_rs1_idx = 5'd8; bus.in_rs1_val = 32'hDEAD_BEEF; bus.in_rd = 5'd4;
        bus.in_is_ecall = 1'b0; bus.in_is_mret = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst-write csr_we before rst", 64'(bus.csr_we), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst-write csr_we drops", 64'(bus.csr_we), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst-write idle", 64'(bus.in_ready), 64'd1);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid || bus.csr_we || bus.csr_ecall) cnt++;
        end
        chk("rst-write no late activity", 64'(cnt), 64'd0);
        chk("rst-write csr unchanged", 64'(csr_mem[12'h340]), 64'h1234);

        addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h340;
        addrs[3] = 12'h341; addrs[4] = 12'h342;
        for (int i = 0; i < 40; i++) begin
            op.pc    = $urandom & 32'hFFFF_FFFC;
            op.f3    = 3'($urandom_range(0, 7));
            op.addr  = addrs[$urandom_range(0, 4)];
            op.rs1   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            op.rs1v  = $urandom;
            op.rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            op.ecall = ($urandom_range(0, 9) == 0);
            op.mret  = ($urandom_range(0, 9) == 0);
            e = model(op);
            do_op($sformatf("rnd%0d", i), op, $urandom_range(0, 3), g);
            compare($sformatf("rnd%0d", i), e, g);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
